// File: rtl/l2_cache_assoc.sv
// l2_cache_assoc: N-way set-associative write-back/write-allocate cache with true-LRU age counters.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.

module l2_cache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 1024,
  parameter int WAYS       = 4
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FETCH  = 3'd3,
    FILL   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t                  state_r, state_next_s;
  logic                    req_ready_r, rsp_valid_r, mem_req_valid_r, mem_req_write_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r, mem_req_wdata_r, req_wdata_r;
  logic [ADDR_WIDTH-1:0]   mem_req_addr_r, req_addr_r;
  logic                    req_write_r;
  logic [STRB_W-1:0]       req_wstrb_r;
  logic [AGE_W-1:0]        victim_r;

  logic [WAYS-1:0]         valid_r [SETS];
  logic [WAYS-1:0]         dirty_r [SETS];
  logic [AGE_W-1:0]        age_r   [SETS][WAYS];
  logic [TAG_W-1:0]        tag_mem [SETS][WAYS];
  logic [DATA_WIDTH-1:0]   data_mem[SETS][WAYS];

  logic [IDX_W-1:0]        idx_s;
  logic [TAG_W-1:0]        tag_s;
  logic [WAYS-1:0]         hit_vec_s, lru_vec_s;
  logic                    hit_s, victim_dirty_s, fill_s, access_s;
  logic [AGE_W-1:0]        hit_way_s, victim_s, acc_way_s, old_age_s;
  logic [DATA_WIDTH-1:0]   hit_line_s, victim_line_s;
  logic [TAG_W-1:0]        victim_tag_s;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_line,
                                                        input logic [DATA_WIDTH-1:0] wdata,
                                                        input logic [STRB_W-1:0]     wstrb);
    merge_bytes = old_line;
    for (int b = 0; b < STRB_W; b++)
      if (wstrb[b]) merge_bytes[b*8 +: 8] = wdata[b*8 +: 8];
  endfunction

  function automatic logic [AGE_W-1:0] lowest_set(input logic [WAYS-1:0] vec);
    lowest_set = {AGE_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--)
      if (vec[w]) lowest_set = AGE_W'(w);
  endfunction

  assign idx_s = IDX_W'(req_addr_r >> OFF_W);
  assign tag_s = TAG_W'(req_addr_r >> (OFF_W + IDX_W));

  // Tag compare across all ways and victim choice: first invalid way, else the oldest.
  always_comb begin
    hit_vec_s = {WAYS{1'b0}};
    lru_vec_s = {WAYS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_r[idx_s][w] && (tag_mem[idx_s][w] == tag_s);
      lru_vec_s[w] = (age_r[idx_s][w] == AGE_W'(WAYS - 1));
    end
    hit_s          = |hit_vec_s;
    hit_way_s      = lowest_set(hit_vec_s);
    victim_s       = (&valid_r[idx_s]) ? lowest_set(lru_vec_s) : lowest_set(~valid_r[idx_s]);
    hit_line_s     = data_mem[idx_s][hit_way_s];
    victim_line_s  = data_mem[idx_s][victim_s];
    victim_tag_s   = tag_mem[idx_s][victim_s];
    victim_dirty_s = dirty_r[idx_s][victim_s];
    fill_s         = (state_r == FILL) && mem_rsp_valid;
    access_s       = fill_s || ((state_r == LOOKUP) && hit_s);
    acc_way_s      = fill_s ? victim_r : hit_way_s;
    old_age_s      = age_r[idx_s][acc_way_s];
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (req_valid && req_ready_r) state_next_s = LOOKUP; else state_next_s = IDLE;
      LOOKUP:  if (hit_s) state_next_s = RESP;
               else if (victim_dirty_s) state_next_s = WB;
               else state_next_s = FETCH;
      WB:      if (mem_req_ready) state_next_s = FETCH; else state_next_s = WB;
      FETCH:   if (mem_req_ready) state_next_s = FILL; else state_next_s = FETCH;
      FILL:    if (mem_rsp_valid) state_next_s = RESP; else state_next_s = FILL;
      RESP:    if (rsp_ready) state_next_s = IDLE; else state_next_s = RESP;
      default: state_next_s = IDLE;
    endcase
  end

  // Control state, registered outputs, valid/dirty bits and LRU ages.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_r         <= IDLE;
      req_ready_r     <= 1'b0;
      rsp_valid_r     <= 1'b0;
      rsp_rdata_r     <= {DATA_WIDTH{1'b0}};
      mem_req_valid_r <= 1'b0;
      mem_req_write_r <= 1'b0;
      mem_req_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_req_wdata_r <= {DATA_WIDTH{1'b0}};
      req_write_r     <= 1'b0;
      req_addr_r      <= {ADDR_WIDTH{1'b0}};
      req_wdata_r     <= {DATA_WIDTH{1'b0}};
      req_wstrb_r     <= {STRB_W{1'b0}};
      victim_r        <= {AGE_W{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        dirty_r[s] <= {WAYS{1'b0}};
        for (int w = 0; w < WAYS; w++) age_r[s][w] <= AGE_W'(w);
      end
    end else begin
      state_r         <= state_next_s;
      req_ready_r     <= (state_next_s == IDLE);
      rsp_valid_r     <= (state_next_s == RESP);
      mem_req_valid_r <= (state_next_s == WB) || (state_next_s == FETCH);
      mem_req_write_r <= (state_next_s == WB);
      if ((state_r == IDLE) && req_valid && req_ready_r) begin
        req_write_r <= req_write;
        req_addr_r  <= req_addr & LINE_MASK;
        req_wdata_r <= req_wdata;
        req_wstrb_r <= req_wstrb;
      end
      if (state_r == LOOKUP) begin
        victim_r <= victim_s;
        if (hit_s) begin
          rsp_rdata_r <= req_write_r ? {DATA_WIDTH{1'b0}} : hit_line_s;
          if (req_write_r) dirty_r[idx_s][hit_way_s] <= 1'b1;
        end
        if (!hit_s && victim_dirty_s) begin
          mem_req_addr_r  <= ADDR_WIDTH'({victim_tag_s, idx_s}) << OFF_W;
          mem_req_wdata_r <= victim_line_s;
        end
      end
      if ((state_next_s == FETCH) && (state_r != FETCH)) mem_req_addr_r <= req_addr_r;
      if (fill_s) begin
        rsp_rdata_r               <= req_write_r ? {DATA_WIDTH{1'b0}} : mem_rsp_rdata;
        valid_r[idx_s][victim_r]  <= 1'b1;
        dirty_r[idx_s][victim_r]  <= req_write_r;
      end
      if (access_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == acc_way_s) age_r[idx_s][w] <= {AGE_W{1'b0}};
          else if (age_r[idx_s][w] < old_age_s) age_r[idx_s][w] <= age_r[idx_s][w] + 1'b1;
        end
      end
    end
  end

  // Tag and data arrays carry no reset; validity is tracked in valid_r.
  always_ff @(posedge s_axi_aclk) begin
    if ((state_r == LOOKUP) && hit_s && req_write_r)
      data_mem[idx_s][hit_way_s] <= merge_bytes(hit_line_s, req_wdata_r, req_wstrb_r);
    if (fill_s) begin
      tag_mem[idx_s][victim_r]  <= tag_s;
      data_mem[idx_s][victim_r] <= req_write_r ? merge_bytes(mem_rsp_rdata, req_wdata_r, req_wstrb_r)
                                               : mem_rsp_rdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_r, miss_count_r;

  // Saturating hit/miss counters, stepped in the lookup cycle.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else if (state_r == LOOKUP) begin
      if (hit_s) begin
        if (hit_count_r != 32'hFFFF_FFFF) hit_count_r <= hit_count_r + 32'd1;
      end else begin
        if (miss_count_r != 32'hFFFF_FFFF) miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`endif

  assign req_ready     = req_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_write = mem_req_write_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign mem_req_wdata = mem_req_wdata_r;

endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb_l2_cache_assoc: randomized self-checking bench for l2_cache_assoc (default parameters)
// against a recency-list cache model and a sparse backing-memory model.

module tb_l2_cache_assoc;

  localparam int SETS = 1024;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  l2_cache_assoc dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
`ifdef CACHE_STATS_EN
    .hit_count     (hit_count),
    .miss_count    (miss_count),
`endif
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  typedef struct packed {
    logic [19:0] tag;
    logic [31:0] data;
    logic        dirty;
  } line_t;

  line_t       set_q [SETS][$];          // front = most recently used
  logic [31:0] mem_model [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          n_hit  = 0;
  int          n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] st);
    merge = old_v;
    for (int b = 0; b < 4; b++)
      if (st[b]) merge[b*8 +: 8] = wd[b*8 +: 8];
  endfunction

  function automatic logic [31:0] backing_read(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < SETS; i++) set_q[i].delete();
    n_hit  = 0;
    n_miss = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"},     64'(req_ready),     64'd0);
    check_eq({tag, "_rsp_valid"},     64'(rsp_valid),     64'd0);
    check_eq({tag, "_rsp_rdata"},     64'(rsp_rdata),     64'd0);
    check_eq({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check_eq({tag, "_mem_req_write"}, 64'(mem_req_write), 64'd0);
    check_eq({tag, "_mem_req_addr"},  64'(mem_req_addr),  64'd0);
    check_eq({tag, "_mem_req_wdata"}, 64'(mem_req_wdata), 64'd0);
  endtask

  // Wait for a downstream request, hold it off for dly cycles, then accept it.
  task automatic serve_mem(input logic wr, input logic [31:0] a, input logic [31:0] d, input int dly);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("mem_req_seen", 64'(mem_req_valid), 64'd1);
    for (int c = 0; c <= dly; c++) begin
      check_eq("mem_req_valid", 64'(mem_req_valid), 64'd1);
      check_eq("mem_req_write", 64'(mem_req_write), 64'(wr));
      check_eq("mem_req_addr",  64'(mem_req_addr),  64'(a));
      if (wr) check_eq("mem_req_wdata", 64'(mem_req_wdata), 64'(d));
      check_eq("req_ready_busy", 64'(req_ready), 64'd0);
      if (c == dly) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int mdly, input int rdly, input bit abort_fill);
    int          si, found, n;
    logic [19:0] tg;
    logic [31:0] line, exp_rd, fdata, wb_addr, wb_data;
    bit          hit, wb;
    line_t       ln, v;
    si = int'(addr[11:2]);
    tg = addr[31:12];
    line = {addr[31:2], 2'b00};
    hit = 1'b0; wb = 1'b0; found = -1; fdata = 32'd0; wb_addr = 32'd0; wb_data = 32'd0;
    for (int i = 0; i < set_q[si].size(); i++)
      if (set_q[si][i].tag == tg) found = i;
    if (found >= 0) begin
      hit = 1'b1;
      ln = set_q[si][found];
      set_q[si].delete(found);
      n_hit++;
    end else begin
      n_miss++;
      if (set_q[si].size() == WAYS) begin
        v = set_q[si].pop_back();
        if (v.dirty) begin
          wb = 1'b1;
          wb_addr = {v.tag, addr[11:2], 2'b00};
          wb_data = v.data;
          mem_model[wb_addr] = v.data;
        end
      end
      fdata = backing_read(line);
      ln = '{tag: tg, data: fdata, dirty: 1'b0};
    end
    exp_rd = wr ? 32'd0 : ln.data;
    if (wr) begin
      ln.data  = merge(ln.data, wd, st);
      ln.dirty = 1'b1;
    end
    set_q[si].push_front(ln);

    // stray fetch data while idle must be ignored
    if ($urandom_range(0, 3) == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = $urandom;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    check_eq("lookup_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("lookup_req_ready", 64'(req_ready), 64'd0);
    if (hit) begin
      @(negedge clk);
      check_eq("hit_latency", 64'(rsp_valid), 64'd1);
      check_eq("hit_no_mem", 64'(mem_req_valid), 64'd0);
    end else begin
      if (wb) serve_mem(1'b1, wb_addr, wb_data, mdly);
      serve_mem(1'b0, line, 32'd0, mdly);
      if (abort_fill) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_eq("fill_no_rsp", 64'(rsp_valid), 64'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = fdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int c = 0; c <= rdly; c++) begin
      check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
      check_eq("rsp_req_ready", 64'(req_ready), 64'd0);
      if (c == rdly) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check_eq("rsp_done", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
    rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
    clear_model();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    mem_model[32'h0000_1000] = 32'hDEAD_BEEF;
    access(1'b0, 32'h0000_1000, 32'd0, 4'h0, 0, 0, 1'b0);
    access(1'b0, 32'h0000_1000, 32'd0, 4'h0, 0, 0, 1'b0);
    access(1'b1, 32'h0000_1000, 32'h0000_00AA, 4'b0001, 0, 0, 1'b0);
    access(1'b0, 32'h0000_1000, 32'd0, 4'h0, 0, 1, 1'b0);
    access(1'b0, 32'h0000_0000, 32'd0, 4'h0, 1, 0, 1'b0);
    access(1'b0, 32'h0000_2000, 32'd0, 4'h0, 0, 2, 1'b0);
    access(1'b0, 32'h0000_3000, 32'd0, 4'h0, 2, 0, 1'b0);
    access(1'b0, 32'h0000_4000, 32'd0, 4'h0, 5, 10, 1'b0);
    access(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1'b0);
    access(1'b0, 32'h0000_0000, 32'd0, 4'h0, 0, 0, 1'b0);
    access(1'b0, 32'h0000_5000, 32'd0, 4'h0, 1, 1, 1'b1);
    access(1'b0, 32'h0000_1000, 32'd0, 4'h0, 0, 0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      access(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

`ifdef CACHE_STATS_EN
    check_eq("hit_count",  64'(hit_count),  64'(n_hit));
    check_eq("miss_count", 64'(miss_count), 64'(n_miss));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
